// File: rtl/fp_round_pipe_if.sv
// Handshake bundle for the FP rounding stage: upstream beat (in_*) and rounded result (out_*).
// The master modport is the producer/consumer side, and the slave modport is the rounding block.
interface fp_round_pipe_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [MANT_W+3:0] in_sig;
  logic [EXP_W-1:0]  in_exp;
  logic              in_sign;
  logic [2:0]        in_rmode;

  logic              out_valid;
  logic              out_ready;
  logic [MANT_W-1:0] out_frac;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sign;
  logic              out_inexact;
  logic              out_overflow;
  logic              out_mode_err;

  modport master (
    output in_valid, in_sig, in_exp, in_sign, in_rmode, out_ready,
    input  in_ready, out_valid, out_frac, out_exp, out_sign,
           out_inexact, out_overflow, out_mode_err
  );

  modport slave (
    input  in_valid, in_sig, in_exp, in_sign, in_rmode, out_ready,
    output in_ready, out_valid, out_frac, out_exp, out_sign,
           out_inexact, out_overflow, out_mode_err
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding pipeline. Stage 1 makes the round-up decision, and stage 2 applies it
// and renormalises. Both stages use a valid/ready handshake and sustain one beat per cycle.
module fp_round_pipe #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input logic          clk,
  input logic          rst_n,
  fp_round_pipe_if.slave bus
);

  localparam int                SIG_W   = MANT_W + 1;
  localparam logic [EXP_W-1:0]  EXP_MAX = '1;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  // Stage 1 state
  logic              s1_valid;
  logic              s1_sign;
  logic [EXP_W-1:0]  s1_exp;
  logic [SIG_W-1:0]  s1_sig;
  logic              s1_inc;
  logic              s1_inexact;
  logic              s1_mode_err;
  logic              s1_special;

  // Output (stage 2) state
  logic              out_valid_q;
  logic [MANT_W-1:0] out_frac_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic              out_sign_q;
  logic              out_inexact_q;
  logic              out_overflow_q;
  logic              out_mode_err_q;

  logic s2_adv;
  logic s1_ready;

  assign s2_adv   = !out_valid_q || bus.out_ready;
  assign s1_ready = !s1_valid || s2_adv;

  // Stage 1 decision logic
  logic g_bit, r_bit, s_bit, lsb_bit, any_rem;
  logic in_special, in_mode_err, inc_d, inexact_d;

  always_comb begin
    g_bit       = bus.in_sig[2];
    r_bit       = bus.in_sig[1];
    s_bit       = bus.in_sig[0];
    lsb_bit     = bus.in_sig[3];
    any_rem     = g_bit | r_bit | s_bit;
    in_special  = (bus.in_exp == EXP_MAX);
    in_mode_err = (bus.in_rmode > 3'd4);
    inc_d       = 1'b0;
    case (bus.in_rmode)
      RM_RNE:  inc_d = g_bit & (r_bit | s_bit | lsb_bit);
      RM_RTZ:  inc_d = 1'b0;
      RM_RDN:  inc_d = bus.in_sign & any_rem;
      RM_RUP:  inc_d = !bus.in_sign & any_rem;
      RM_RMM:  inc_d = g_bit;
      default: inc_d = 1'b0;
    endcase
    inexact_d = any_rem;
    // Inf/NaN must pass through untouched, with no rounding side effects.
    if (in_special) begin
      inc_d     = 1'b0;
      inexact_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_sig      <= '0;
      s1_inc      <= 1'b0;
      s1_inexact  <= 1'b0;
      s1_mode_err <= 1'b0;
      s1_special  <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign     <= bus.in_sign;
        s1_exp      <= bus.in_exp;
        s1_sig      <= bus.in_sig[MANT_W+3:3];
        s1_inc      <= inc_d;
        s1_inexact  <= inexact_d;
        s1_mode_err <= in_mode_err;
        s1_special  <= in_special;
      end
    end
  end

  // Stage 2: apply the increment; a carry out of the hidden bit shifts right and bumps the exponent
  logic [MANT_W+1:0] sum;
  logic              carry;
  logic [MANT_W-1:0] frac_d;
  logic [EXP_W-1:0]  exp_d;
  logic              overflow_d;
  logic              inexact2_d;

  always_comb begin
    sum        = {1'b0, s1_sig} + {{(MANT_W+1){1'b0}}, s1_inc};
    carry      = sum[MANT_W+1];
    frac_d     = carry ? sum[MANT_W:1] : sum[MANT_W-1:0];
    exp_d      = s1_exp + {{(EXP_W-1){1'b0}}, carry};
    overflow_d = !s1_special && (exp_d == EXP_MAX);
    inexact2_d = s1_inexact;
    if (overflow_d) begin
      frac_d     = '0;
      inexact2_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_frac_q     <= '0;
      out_exp_q      <= '0;
      out_sign_q     <= 1'b0;
      out_inexact_q  <= 1'b0;
      out_overflow_q <= 1'b0;
      out_mode_err_q <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_frac_q     <= frac_d;
        out_exp_q      <= exp_d;
        out_sign_q     <= s1_sign;
        out_inexact_q  <= inexact2_d;
        out_overflow_q <= overflow_d;
        out_mode_err_q <= s1_mode_err;
      end
    end
  end

  assign bus.in_ready     = s1_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_frac     = out_frac_q;
  assign bus.out_exp      = out_exp_q;
  assign bus.out_sign     = out_sign_q;
  assign bus.out_inexact  = out_inexact_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_mode_err = out_mode_err_q;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Bench for fp_round_pipe: directed rounding cases, backpressure, mid-flight reset and random beats.
// Every output beat is checked against an arithmetic rounding model through a scoreboard queue.
module tb_fp_round_pipe;
  localparam int MANT_W = 23;
  localparam int EXP_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_round_pipe_if #(.MANT_W(MANT_W), .EXP_W(EXP_W)) bus ();
  fp_round_pipe #(.MANT_W(MANT_W), .EXP_W(EXP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [22:0] frac;
    logic [7:0]  exp;
    logic        sign;
    logic        inexact;
    logic        overflow;
    logic        mode_err;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    rand_ready = 0;
  bit    stall_prev = 0;
  beat_t snap;

  // Rounding reference: round-up decision from the remainder value, then plain integer arithmetic
  function automatic beat_t model(input logic [26:0] sig, input logic [7:0] e,
                                  input logic sign, input logic [2:0] rm);
    beat_t  b;
    longint mant = longint'(sig[26:3]);
    int     grs  = int'(sig[2:0]);
    int     ex   = int'(e);
    bit     up   = 0;
    b.sign     = sign;
    b.mode_err = (rm > 3'd4);
    b.overflow = 1'b0;
    if (ex == 255) begin
      b.frac    = mant[22:0];
      b.exp     = e;
      b.inexact = 1'b0;
      return b;
    end
    case (rm)
      3'd0:    up = (grs > 4) || (grs == 4 && (mant % 2) == 1);
      3'd2:    up = sign && grs != 0;
      3'd3:    up = !sign && grs != 0;
      3'd4:    up = grs >= 4;
      default: up = 0;
    endcase
    mant = mant + (up ? 1 : 0);
    if (mant >= (longint'(1) << 24)) begin
      mant = mant / 2;
      ex   = ex + 1;
    end
    b.frac    = mant[22:0];
    b.exp     = ex[7:0];
    b.inexact = (grs != 0);
    if (ex == 255) begin
      b.frac     = '0;
      b.overflow = 1'b1;
      b.inexact  = 1'b1;
    end
    return b;
  endfunction

  task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  task automatic compare_beat(input string tag, input beat_t want);
    check_field({tag, ".frac"},     32'(bus.out_frac),     32'(want.frac));
    check_field({tag, ".exp"},      32'(bus.out_exp),      32'(want.exp));
    check_field({tag, ".sign"},     32'(bus.out_sign),     32'(want.sign));
    check_field({tag, ".inexact"},  32'(bus.out_inexact),  32'(want.inexact));
    check_field({tag, ".overflow"}, 32'(bus.out_overflow), 32'(want.overflow));
    check_field({tag, ".mode_err"}, 32'(bus.out_mode_err), 32'(want.mode_err));
  endtask

  // Scoreboard: sampled on the falling edge, so handshakes reflect the upcoming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check_field("stall.valid", 32'(bus.out_valid), 32'd1);
        compare_beat("stall", snap);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_beat got=exp %0h want=no beat", bus.out_exp);
        end
        if (exp_q.size() != 0) compare_beat("out", exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_sig, bus.in_exp, bus.in_sign, bus.in_rmode));
      stall_prev = bus.out_valid && !bus.out_ready;
      if (stall_prev) begin
        snap.frac     = bus.out_frac;
        snap.exp      = bus.out_exp;
        snap.sign     = bus.out_sign;
        snap.inexact  = bus.out_inexact;
        snap.overflow = bus.out_overflow;
        snap.mode_err = bus.out_mode_err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic apply_stimulus(input logic [26:0] sig, input logic [7:0] e,
                                input logic sign, input logic [2:0] rm);
    bit done = 0;
    bus.in_sig   = sig;
    bus.in_exp   = e;
    bus.in_sign  = sign;
    bus.in_rmode = rm;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = bus.in_ready;
      tick();
    end
    checks++;
    assert (done) else begin
      errors++;
      $error("[TB] FAIL accept_timeout got=in_ready low want=accept");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [22:0] frac, input logic [7:0] e,
                              input logic sign, input logic inexact, input logic overflow,
                              input logic mode_err);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.out_valid;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("[TB] FAIL %s.timeout got=no out_valid want=out_valid", tag);
    end
    if (seen) begin
      check_field({tag, ".frac"},     32'(bus.out_frac),     32'(frac));
      check_field({tag, ".exp"},      32'(bus.out_exp),      32'(e));
      check_field({tag, ".sign"},     32'(bus.out_sign),     32'(sign));
      check_field({tag, ".inexact"},  32'(bus.out_inexact),  32'(inexact));
      check_field({tag, ".overflow"}, 32'(bus.out_overflow), 32'(overflow));
      check_field({tag, ".mode_err"}, 32'(bus.out_mode_err), 32'(mode_err));
    end
    tick();
  endtask

  task automatic drain();
    bit empty = 0;
    for (int i = 0; i < 100 && !empty; i++) begin
      @(negedge clk);
      empty = (exp_q.size() == 0) && !bus.out_valid;
      tick();
    end
    check_field("drain.pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_field({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    check_field({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    check_field({tag, ".out_frac"},  32'(bus.out_frac),  32'd0);
    check_field({tag, ".out_exp"},   32'(bus.out_exp),   32'd0);
    check_field({tag, ".flags"},
                32'({bus.out_sign, bus.out_inexact, bus.out_overflow, bus.out_mode_err}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=still running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [26:0] sig;
    logic [7:0]  e;

    bus.in_valid  = 1'b0;
    bus.in_sig    = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.in_rmode  = 3'd0;
    bus.out_ready = 1'b0;

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    $display("[TB] directed rounding");
    apply_stimulus({24'h800000, 3'b100}, 8'h40, 1'b0, 3'd0);
    @(negedge clk);
    check_field("latency.early", 32'(bus.out_valid), 32'd0);
    check_output("rne_tie_even", 23'h000000, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'h800001, 3'b100}, 8'h40, 1'b0, 3'd0);
    check_output("rne_tie_odd", 23'h000002, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'h800001, 3'b101}, 8'h40, 1'b0, 3'd0);
    check_output("rne_above", 23'h000002, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'hFFFFFF, 3'b110}, 8'h10, 1'b0, 3'd0);
    check_output("carry", 23'h000000, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'hFFFFFF, 3'b100}, 8'hFE, 1'b0, 3'd0);
    check_output("ovf_rne", 23'h000000, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
    apply_stimulus({24'hFFFFFF, 3'b100}, 8'hFE, 1'b0, 3'd1);
    check_output("ovf_rtz", 23'h7FFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'hFFFFFF, 3'b100}, 8'hFE, 1'b1, 3'd3);
    check_output("ovf_rup_neg", 23'h7FFFFF, 8'hFE, 1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'hFFFFFF, 3'b100}, 8'hFE, 1'b1, 3'd2);
    check_output("ovf_rdn_neg", 23'h000000, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
    apply_stimulus({24'h800002, 3'b100}, 8'h20, 1'b0, 3'd4);
    check_output("rmm_tie", 23'h000003, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'h800000, 3'b001}, 8'h20, 1'b0, 3'd3);
    check_output("rup_sticky", 23'h000001, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus({24'hC00000, 3'b111}, 8'hFF, 1'b0, 3'd0);
    check_output("special", 23'h400000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus({24'h812345, 3'b111}, 8'h30, 1'b0, 3'd7);
    check_output("reserved_mode", 23'h012345, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    apply_stimulus({24'h800000, 3'b000}, 8'h01, 1'b0, 3'd0);
    apply_stimulus({24'h800000, 3'b000}, 8'h02, 1'b0, 3'd0);
    check_field("bp.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_sig   = {24'h800000, 3'b000};
    bus.in_exp   = 8'h03;
    bus.in_valid = 1'b1;
    tick();
    tick();
    check_field("bp.held_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    apply_stimulus({24'h800000, 3'b000}, 8'h03, 1'b0, 3'd0);
    apply_stimulus({24'h800000, 3'b000}, 8'h04, 1'b0, 3'd0);
    drain();

    $display("[TB] reset mid-flight");
    bus.out_ready = 1'b0;
    apply_stimulus({24'h900000, 3'b000}, 8'h05, 1'b0, 3'd0);
    apply_stimulus({24'h900000, 3'b000}, 8'h06, 1'b0, 3'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_field("midreset.stale", 32'(bus.out_valid), 32'd0);
    end
    tick();

    $display("[TB] random traffic");
    rand_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        r   = $urandom;
        sig = r[26:0];
        if ($urandom_range(0, 3) == 0) sig[26:3] = '1;
        case ($urandom_range(0, 5))
          0:       e = 8'hFE;
          1:       e = 8'hFF;
          2:       e = 8'h00;
          default: e = 8'($urandom);
        endcase
        apply_stimulus(sig, e, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end else begin
        tick();
      end
    end
    rand_ready = 0;
    bus.out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
